// File: rtl/mem_access_unit.sv
// Single-outstanding CPU-to-memory access unit: decodes the address map and
// sequences one access per request (strobe, wait, response).
module mem_access_unit #(
    parameter int unsigned WAIT_CYCLES = 1,
    localparam int unsigned ADDR_W = 16,
    localparam int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned WAIT_LOAD_I = (WAIT_CYCLES == 32'd0) ? 32'd0 : WAIT_CYCLES - 32'd1;
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(WAIT_LOAD_I);
    localparam logic [ADDR_W-1:0] LOW_END   = 16'h003F;
    localparam logic [ADDR_W-1:0] HIGH_BASE = 16'h0800;
    localparam logic [ADDR_W-1:0] HIGH_END  = 16'h0FFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   wait_cnt_d;
    logic               we_q;
    logic               we_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  wdata_d;

    logic               req_ready_d;
    logic               busy_d;
    logic               rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_d;
    logic               rsp_err_d;
    logic [ADDR_W-1:0]  mem_address_d;
    logic [DATA_W-1:0]  mem_wdata_d;
    logic               mem_we_d;

    logic               accept_c;
    logic               mapped_c;

    assign accept_c = req_valid && (state == IDLE);
    assign mapped_c = (req_addr <= LOW_END) || ((req_addr >= HIGH_BASE) && (req_addr <= HIGH_END));

    // State register; all ports are flops loaded from the next-cycle decode.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
        end else begin
            state       <= next_state;
            wait_cnt    <= wait_cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready   <= req_ready_d;
            busy        <= busy_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            mem_address <= mem_address_d;
            mem_wdata   <= mem_wdata_d;
            mem_we      <= mem_we_d;
        end
    end

    // Next-state decode; WAIT is skipped entirely when WAIT_CYCLES is 0.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    next_state = mapped_c ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                next_state = (WAIT_CYCLES == 32'd0) ? RESP : WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output and datapath decode for the next cycle.
    always_comb begin
        req_ready_d   = (next_state == IDLE);
        busy_d        = (next_state != IDLE);
        rsp_valid_d   = (next_state == RESP);
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        mem_address_d = '0;
        mem_wdata_d   = '0;
        mem_we_d      = 1'b0;
        wait_cnt_d    = wait_cnt;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    rsp_rdata_d = '0;
                    rsp_err_d   = !mapped_c;
                    if (mapped_c) begin
                        mem_address_d = req_addr;
                        mem_wdata_d   = req_wdata;
                        mem_we_d      = req_we;
                    end
                end
            end
            ACCESS, WAIT: begin
                if (next_state == WAIT) begin
                    mem_address_d = addr_q;
                    mem_wdata_d   = wdata_q;
                    wait_cnt_d    = (state == ACCESS) ? WAIT_LOAD : wait_cnt - CNT_W'(1);
                end else begin
                    // Read data is sampled on the edge that leaves the access phase.
                    rsp_rdata_d = we_q ? '0 : mem_rdata;
                    rsp_err_d   = 1'b0;
                    wait_cnt_d  = '0;
                end
            end
            RESP: begin
                if (next_state == IDLE) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                wait_cnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: scoreboarded requests on a WAIT_CYCLES=1
// instance plus a back-to-back stream on a WAIT_CYCLES=0 instance.
module tb_mem_access_unit;

    localparam int unsigned W1 = 1;

    logic        clock = 1'b0;
    logic        reset_n;
    always #5 clock = ~clock;

    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, mem_we, busy;
    logic [15:0] req_addr, mem_address;
    logic [31:0] req_wdata, rsp_rdata, mem_wdata, mem_rdata;

    logic        req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_err0, mem_we0, busy0;
    logic [15:0] req_addr0, mem_address0;
    logic [31:0] req_wdata0, rsp_rdata0, mem_wdata0, mem_rdata0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_q[$];
    logic [32:0] exp_q0[$];

    function automatic logic is_mapped(input logic [15:0] a);
        return (a <= 16'h003F) || ((a >= 16'h0800) && (a <= 16'h0FFF));
    endfunction

    function automatic logic [31:0] model_rdata(input logic [15:0] a);
        if (a == 16'h0805) return 32'hDEADBEEF;
        return {~a, a};
    endfunction

    assign mem_rdata  = model_rdata(mem_address);
    assign mem_rdata0 = model_rdata(mem_address0);

    mem_access_unit #(.WAIT_CYCLES(W1)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_access_unit #(.WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .mem_address(mem_address0), .mem_wdata(mem_wdata0), .mem_we(mem_we0),
        .mem_rdata(mem_rdata0), .busy(busy0)
    );

    // Memory-side monitor: strobe count, back-to-back strobes, bus activity outside an access.
    int          we_count  = 0;
    int          we_count0 = 0;
    int          double_we = 0;
    int          idle_viol = 0;
    logic        prev_we   = 1'b0;
    logic [15:0] we_addr   = '0;
    logic [31:0] we_data   = '0;
    always @(negedge clock) begin
        if (mem_we) begin
            we_count++;
            we_addr = mem_address;
            we_data = mem_wdata;
            if (prev_we) double_we++;
        end
        prev_we = mem_we;
        if (mem_we0) we_count0++;
        if (reset_n && (!busy || rsp_valid) && (mem_we || mem_address != 16'h0 || mem_wdata != 32'h0))
            idle_viol++;
        if (reset_n && (!busy0 || rsp_valid0) && (mem_we0 || mem_address0 != 16'h0 || mem_wdata0 != 32'h0))
            idle_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [15:0] addr, input logic [31:0] wdata, input int stall);
        int          k;
        int          we0;
        logic        mapped;
        logic [32:0] e;
        mapped = is_mapped(addr);
        k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        check("req_ready_idle", 32'(req_ready), 32'(1));
        we0       = we_count;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        exp_q.push_back({!mapped, (mapped && !we) ? model_rdata(addr) : 32'h0});
        @(posedge clock); #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        // k = the edge (counted from acceptance) at which rsp_valid is sampled high
        k = 1;
        while (!rsp_valid && k < 40) begin
            @(posedge clock); #1;
            k++;
        end
        check("latency", 32'(k), mapped ? 32'(2 + W1) : 32'(1));
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'(1), 32'(0));
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check("rsp_rdata", rsp_rdata, e[31:0]);
        check("rsp_err", 32'(rsp_err), 32'(e[32]));
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1;
            req_addr  = 16'h0001;
            @(posedge clock); #1;
            check("stall_rsp_valid", 32'(rsp_valid), 32'(1));
            check("stall_rsp_rdata", rsp_rdata, e[31:0]);
            check("stall_req_ready", 32'(req_ready), 32'(0));
        end
        req_valid = 1'b0;
        req_addr  = '0;
        check("dead_cycle_ready", 32'(req_ready), 32'(0));
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'(0));
        check("post_rsp_busy", 32'(busy), 32'(0));
        check("mem_we_pulses", 32'(we_count - we0), (mapped && we) ? 32'(1) : 32'(0));
    endtask

    logic [15:0] bnd [6];
    logic [15:0] b2b [4];

    initial begin
        int   we0;
        int   last_rsp;
        int   n_rsp;
        int   idx;
        logic seen;
        logic acc;
        logic [32:0] e0;

        reset_n    = 1'b0;
        req_valid  = 1'b0; req_we  = 1'b0; req_addr  = '0; req_wdata  = '0; rsp_ready  = 1'b0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; rsp_ready0 = 1'b0;
        bnd = '{16'h003F, 16'h0040, 16'h07FF, 16'h0800, 16'h0FFF, 16'h1000};
        b2b = '{16'h0001, 16'h0805, 16'h0900, 16'h003E};

        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        check("rst_req_ready", 32'(req_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'(0));
        check("rst_mem_address", 32'(mem_address), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'(0));

        do_req(1'b0, 16'h0805, 32'h0, 0);

        do_req(1'b1, 16'h0020, 32'h0000_000A, 0);
        check("wr_mem_address", 32'(we_addr), 32'h0020);
        check("wr_mem_wdata", we_data, 32'h0000_000A);

        foreach (bnd[i]) do_req(1'b1, bnd[i], 32'h5A00_0000 | 32'(i), 0);
        do_req(1'b0, 16'h0000, 32'h0, 0);
        do_req(1'b0, 16'h0FFF, 32'h0, 0);
        do_req(1'b0, 16'hFFFF, 32'h0, 0);

        do_req(1'b0, 16'h0033, 32'h0, 5);

        // Reset while the write strobe is on the bus.
        we0       = we_count;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0010; req_wdata = 32'h1234_5678;
        @(posedge clock); #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        check("access_mem_we", 32'(mem_we), 32'(1));
        check("access_mem_address", 32'(mem_address), 32'h0010);
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        check("abort_mem_we", 32'(mem_we), 32'(0));
        check("abort_rsp_valid", 32'(rsp_valid), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_req_ready", 32'(req_ready), 32'(1));
        check("abort_mem_address", 32'(mem_address), 32'h0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clock); #1;
            seen = seen | rsp_valid | mem_we;
        end
        check("abort_no_activity", 32'(seen), 32'(0));
        check("abort_we_pulses", 32'(we_count - we0), 32'(1));

        // Back-to-back reads on the zero-wait instance with the response side always ready.
        rsp_ready0 = 1'b1;
        idx        = 0;
        last_rsp   = -1;
        n_rsp      = 0;
        req_valid0 = 1'b1;
        req_addr0  = b2b[0];
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (rsp_valid0) begin
                if (exp_q0.size() == 0) begin
                    check("b2b_scoreboard_empty", 32'(1), 32'(0));
                    e0 = '0;
                end else begin
                    e0 = exp_q0.pop_front();
                end
                check("b2b_rsp_rdata", rsp_rdata0, e0[31:0]);
                check("b2b_rsp_err", 32'(rsp_err0), 32'(e0[32]));
                if (last_rsp >= 0) check("b2b_spacing", 32'(cyc - last_rsp), 32'(3));
                last_rsp = cyc;
                n_rsp++;
            end
            acc = req_valid0 && req_ready0;
            if (acc) exp_q0.push_back({1'b0, model_rdata(req_addr0)});
            @(posedge clock); #1;
            if (acc) begin
                idx++;
                if (idx < 4) req_addr0 = b2b[idx];
                else begin
                    req_valid0 = 1'b0;
                    req_addr0  = '0;
                end
            end
        end
        rsp_ready0 = 1'b0;
        check("b2b_responses", 32'(n_rsp), 32'(4));
        check("b2b_no_mem_we", 32'(we_count0), 32'(0));

        check("mem_we_double", 32'(double_we), 32'(0));
        check("mem_bus_idle", 32'(idle_viol), 32'(0));
        check("scoreboard_drained", 32'(exp_q.size() + exp_q0.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
